// File: rtl/sprite_draw_engine.sv
// Sprite address generator with 90-degree heading rotation, ROM-latency-aligned opaque flag, and per-frame opaque pixel counter.
// Outputs lag the DrawX/DrawY sample by ROM_LAT+2 cycles; sprite position, heading and show are frozen at each vs falling edge.
module sprite_draw_engine #(
  parameter int SPR_W   = 14,
  parameter int ADDR_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vs,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        dir,
  input  logic              show,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [1:0]        rom_idx,
  output logic              sprite_on,
  output logic [1:0]        sprite_idx,
  output logic [7:0]        opaque_count,
  output logic              frame_done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [CW-1:0] M = CW'(SPR_W - 1);

  logic              vs_q;
  logic [9:0]        pos_x_s_q, pos_y_s_q;
  logic [1:0]        dir_s_q;
  logic              show_s_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_q, hit_d;
  logic [ROM_LAT-1:0] hit_dly_q;
  logic              sprite_on_q, sprite_on_d;
  logic [1:0]        sprite_idx_q, sprite_idx_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [7:0]        opaque_count_q, opaque_count_d;
  logic              frame_done_q;

  logic              vs_fall;
  logic [10:0]       dx, dy;
  logic [CW-1:0]     lx, ly, sx, sy;

  assign vs_fall = vs_q & ~vs;

  always_comb begin
    dx    = {1'b0, DrawX} - {1'b0, pos_x_s_q};
    dy    = {1'b0, DrawY} - {1'b0, pos_y_s_q};
    hit_d = blank & show_s_q & (DrawX >= pos_x_s_q) & (dx < 11'(SPR_W))
                             & (DrawY >= pos_y_s_q) & (dy < 11'(SPR_W));
    lx    = dx[CW-1:0];
    ly    = dy[CW-1:0];
    sx    = lx;
    sy    = ly;
    // The ROM holds the "up" image; other headings read it rotated.
    case (dir_s_q)
      2'd1: begin sx = ly;     sy = M - lx; end
      2'd2: begin sx = M - lx; sy = M - ly; end
      2'd3: begin sx = M - ly; sy = lx;     end
      default: ;
    endcase
    rom_addr_d = hit_d ? (ADDR_W'(sx) + ADDR_W'(sy) * ADDR_W'(SPR_W)) : '0;
  end

  always_comb begin
    sprite_on_d    = hit_dly_q[ROM_LAT-1] & (rom_idx != 2'd0);
    sprite_idx_d   = sprite_on_d ? rom_idx : 2'd0;
    cnt_inc        = (sprite_on_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    cnt_d          = vs_fall ? 8'd0 : cnt_inc;
    opaque_count_d = vs_fall ? cnt_inc : opaque_count_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q           <= 1'b0;
      pos_x_s_q      <= '0;
      pos_y_s_q      <= '0;
      dir_s_q        <= '0;
      show_s_q       <= 1'b0;
      rom_addr_q     <= '0;
      hit_q          <= 1'b0;
      hit_dly_q      <= '0;
      sprite_on_q    <= 1'b0;
      sprite_idx_q   <= '0;
      cnt_q          <= '0;
      opaque_count_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      vs_q <= vs;
      if (vs_fall) begin
        pos_x_s_q <= pos_x;
        pos_y_s_q <= pos_y;
        dir_s_q   <= dir;
        show_s_q  <= show;
      end
      rom_addr_q   <= rom_addr_d;
      hit_q        <= hit_d;
      hit_dly_q[0] <= hit_q;
      for (int i = 1; i < ROM_LAT; i++) hit_dly_q[i] <= hit_dly_q[i-1];
      sprite_on_q    <= sprite_on_d;
      sprite_idx_q   <= sprite_idx_d;
      cnt_q          <= cnt_d;
      opaque_count_q <= opaque_count_d;
      frame_done_q   <= vs_fall;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sprite_on    = sprite_on_q;
  assign sprite_idx   = sprite_idx_q;
  assign opaque_count = opaque_count_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: two instances (ROM_LAT 1 and 2) driven by the same raster.
module tb_sprite_draw_engine;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0, vs = 1'b1;
  logic [9:0] pos_x = '0, pos_y = '0;
  logic [1:0] dir = '0;
  logic       show = 1'b0;

  logic [7:0] rom_addr1, rom_addr2;
  logic [1:0] rom_idx1 = '0, rom_idx2 = '0, r2_stage = '0;
  logic       sprite_on1, sprite_on2;
  logic [1:0] sprite_idx1, sprite_idx2;
  logic [7:0] opaque_count1, opaque_count2;
  logic       frame_done1, frame_done2;

  logic       rom_mode = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       pon;
  logic [1:0] pidx;

  always #5 vga_clk = ~vga_clk;

  sprite_draw_engine #(.SPR_W(14), .ADDR_W(8), .ROM_LAT(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vs(vs), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .show(show),
    .rom_addr(rom_addr1), .rom_idx(rom_idx1), .sprite_on(sprite_on1),
    .sprite_idx(sprite_idx1), .opaque_count(opaque_count1), .frame_done(frame_done1));

  sprite_draw_engine #(.SPR_W(14), .ADDR_W(8), .ROM_LAT(2)) dut2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vs(vs), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .show(show),
    .rom_addr(rom_addr2), .rom_idx(rom_idx2), .sprite_on(sprite_on2),
    .sprite_idx(sprite_idx2), .opaque_count(opaque_count2), .frame_done(frame_done2));

  // ROM image: pattern mode returns addr mod 4, opaque mode returns 3 everywhere.
  function automatic logic [1:0] rom_f(input logic [7:0] a);
    return rom_mode ? 2'd3 : a[1:0];
  endfunction

  always @(posedge vga_clk) begin
    rom_idx1 <= rom_f(rom_addr1);
    r2_stage <= rom_f(rom_addr2);
    rom_idx2 <= r2_stage;
  end

  task automatic tick();
    @(posedge vga_clk); #1;
  endtask

  task automatic latch(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d, input logic s);
    pos_x = x; pos_y = y; dir = d; show = s; blank = 1'b0;
    vs = 1'b1; tick();
    vs = 1'b0; tick();
    vs = 1'b1;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic b,
                       output logic on, output logic [1:0] idx);
    DrawX = x; DrawY = y; blank = b;
    tick();
    blank = 1'b0;
    tick(); tick();
    on = sprite_on1; idx = sprite_idx1;
  endtask

  task automatic addr_probe(input logic [9:0] x, input logic [9:0] y, output logic [7:0] a);
    DrawX = x; DrawY = y; blank = 1'b1;
    tick();
    a = rom_addr1;
    blank = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (rom_addr1 !== 8'd0) $display("FAIL reset_rom_addr got %0d exp 0", rom_addr1); else n_pass++;
    n_checks++; if (sprite_on1 !== 1'b0) $display("FAIL reset_sprite_on got %b exp 0", sprite_on1); else n_pass++;
    n_checks++; if (sprite_idx1 !== 2'd0) $display("FAIL reset_sprite_idx got %0d exp 0", sprite_idx1); else n_pass++;
    n_checks++; if (opaque_count1 !== 8'd0) $display("FAIL reset_opaque_count got %0d exp 0", opaque_count1); else n_pass++;
    n_checks++; if (frame_done1 !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done1); else n_pass++;
    n_checks++; if (sprite_on2 !== 1'b0) $display("FAIL reset_sprite_on2 got %b exp 0", sprite_on2); else n_pass++;
    @(negedge vga_clk); reset_n = 1'b1;
    tick();
  endtask

  task automatic test_address();
    logic [7:0] a;
    logic [7:0] exp_a [0:3];
    logic [9:0] px [0:3];
    logic [9:0] py [0:3];
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    px[0] = 10'd113; py[0] = 10'd63; exp_a[0] = 8'd195;
    px[1] = 10'd100; py[1] = 10'd50; exp_a[1] = 8'd0;
    px[2] = 10'd101; py[2] = 10'd51; exp_a[2] = 8'd15;
    px[3] = 10'd114; py[3] = 10'd50; exp_a[3] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      addr_probe(px[i], py[i], a);
      n_checks++;
      if (a !== exp_a[i]) $display("FAIL addr_up_%0d got %0d exp %0d", i, a, exp_a[i]); else n_pass++;
    end
  endtask

  task automatic test_heading();
    logic [7:0] a;
    logic [1:0] d  [0:4];
    logic [9:0] px [0:4];
    logic [9:0] py [0:4];
    logic [7:0] ea [0:4];
    d[0] = 2'd1; px[0] = 10'd100; py[0] = 10'd50; ea[0] = 8'd182;
    d[1] = 2'd2; px[1] = 10'd100; py[1] = 10'd50; ea[1] = 8'd195;
    d[2] = 2'd3; px[2] = 10'd100; py[2] = 10'd50; ea[2] = 8'd13;
    d[3] = 2'd1; px[3] = 10'd101; py[3] = 10'd50; ea[3] = 8'd168;
    d[4] = 2'd3; px[4] = 10'd100; py[4] = 10'd51; ea[4] = 8'd12;
    for (int i = 0; i < 5; i++) begin
      latch(10'd100, 10'd50, d[i], 1'b1);
      addr_probe(px[i], py[i], a);
      n_checks++;
      if (a !== ea[i]) $display("FAIL addr_dir%0d_%0d got %0d exp %0d", d[i], i, a, ea[i]); else n_pass++;
    end
  endtask

  task automatic test_pipeline();
    localparam int N = 24;
    logic       e_on  [0:N-1];
    logic [1:0] e_idx [0:N-1];
    logic [9:0] x;
    logic       b;
    int         ad;
    rom_mode = 1'b0;
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    for (int k = 0; k < N; k++) begin
      x = 10'(96 + k);
      b = (k != 10);
      ad = (int'(x) - 100) + 2 * 14;
      if (b && x >= 10'd100 && x < 10'd114) begin
        e_idx[k] = 2'(ad % 4);
        e_on[k]  = (e_idx[k] != 2'd0);
      end else begin
        e_idx[k] = 2'd0;
        e_on[k]  = 1'b0;
      end
    end
    for (int k = 0; k < N + 4; k++) begin
      tick();
      if (k >= 3) begin
        n_checks++;
        if (sprite_on1 !== e_on[k-3] || sprite_idx1 !== e_idx[k-3])
          $display("FAIL pipe_lat1_px%0d got on=%b idx=%0d exp on=%b idx=%0d",
                   k-3, sprite_on1, sprite_idx1, e_on[k-3], e_idx[k-3]);
        else n_pass++;
      end
      if (k >= 4) begin
        n_checks++;
        if (sprite_on2 !== e_on[k-4] || sprite_idx2 !== e_idx[k-4])
          $display("FAIL pipe_lat2_px%0d got on=%b idx=%0d exp on=%b idx=%0d",
                   k-4, sprite_on2, sprite_idx2, e_on[k-4], e_idx[k-4]);
        else n_pass++;
      end
      if (k < N) begin
        DrawX = 10'(96 + k); DrawY = 10'd52; blank = (k != 10);
      end else begin
        blank = 1'b0;
      end
    end
  endtask

  task automatic test_shadow_and_clip();
    rom_mode = 1'b0;
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    pos_x = 10'd300;
    probe(10'd101, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b1 || pidx !== 2'd1) $display("FAIL shadow_old_pos got on=%b idx=%0d exp on=1 idx=1", pon, pidx); else n_pass++;
    probe(10'd301, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b0) $display("FAIL shadow_new_pos_early got on=%b exp 0", pon); else n_pass++;
    latch(10'd300, 10'd50, 2'd0, 1'b1);
    probe(10'd301, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b1 || pidx !== 2'd1) $display("FAIL shadow_new_pos got on=%b idx=%0d exp on=1 idx=1", pon, pidx); else n_pass++;
    probe(10'd101, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b0) $display("FAIL shadow_old_pos_gone got on=%b exp 0", pon); else n_pass++;
    latch(10'd630, 10'd50, 2'd0, 1'b1);
    probe(10'd639, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b1 || pidx !== 2'd1) $display("FAIL clip_col639 got on=%b idx=%0d exp on=1 idx=1", pon, pidx); else n_pass++;
    probe(10'd631, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b1 || pidx !== 2'd1) $display("FAIL clip_col631 got on=%b idx=%0d exp on=1 idx=1", pon, pidx); else n_pass++;
    probe(10'd640, 10'd50, 1'b0, pon, pidx);
    n_checks++; if (pon !== 1'b0) $display("FAIL clip_col640 got on=%b exp 0", pon); else n_pass++;
    probe(10'd1, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b0) $display("FAIL clip_nowrap_col1 got on=%b exp 0", pon); else n_pass++;
  endtask

  task automatic frame_end(input logic [7:0] exp_cnt, input string tag);
    blank = 1'b0;
    repeat (4) tick();
    n_checks++; if (frame_done1 !== 1'b0) $display("FAIL %s_done_pre got %b exp 0", tag, frame_done1); else n_pass++;
    vs = 1'b0; tick();
    n_checks++; if (frame_done1 !== 1'b1) $display("FAIL %s_done_pulse got %b exp 1", tag, frame_done1); else n_pass++;
    n_checks++; if (opaque_count1 !== exp_cnt) $display("FAIL %s_count got %0d exp %0d", tag, opaque_count1, exp_cnt); else n_pass++;
    vs = 1'b1; tick();
    n_checks++; if (frame_done1 !== 1'b0) $display("FAIL %s_done_post got %b exp 0", tag, frame_done1); else n_pass++;
    n_checks++; if (opaque_count1 !== exp_cnt) $display("FAIL %s_count_hold got %0d exp %0d", tag, opaque_count1, exp_cnt); else n_pass++;
  endtask

  task automatic scan_sprite_area();
    for (int y = 48; y < 66; y++)
      for (int x = 98; x < 116; x++) begin
        DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1;
        tick();
      end
  endtask

  task automatic test_counter();
    rom_mode = 1'b1;
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    scan_sprite_area();
    frame_end(8'd196, "frame_full");
    DrawX = 10'd105; DrawY = 10'd55; blank = 1'b1;
    repeat (300) tick();
    show = 1'b0;
    frame_end(8'd255, "frame_sat");
    scan_sprite_area();
    frame_end(8'd0, "frame_hidden");
  endtask

  task automatic test_reset_mid_frame();
    rom_mode = 1'b0;
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    DrawX = 10'd101; DrawY = 10'd50; blank = 1'b1;
    repeat (3) tick();
    n_checks++; if (sprite_on1 !== 1'b1) $display("FAIL midrst_pre_on got %b exp 1", sprite_on1); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (sprite_on1 !== 1'b0) $display("FAIL midrst_sprite_on got %b exp 0", sprite_on1); else n_pass++;
    n_checks++; if (sprite_idx1 !== 2'd0) $display("FAIL midrst_sprite_idx got %0d exp 0", sprite_idx1); else n_pass++;
    n_checks++; if (rom_addr1 !== 8'd0) $display("FAIL midrst_rom_addr got %0d exp 0", rom_addr1); else n_pass++;
    n_checks++; if (opaque_count1 !== 8'd0) $display("FAIL midrst_opaque_count got %0d exp 0", opaque_count1); else n_pass++;
    n_checks++; if (frame_done1 !== 1'b0) $display("FAIL midrst_frame_done got %b exp 0", frame_done1); else n_pass++;
    @(negedge vga_clk); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (sprite_on1 !== 1'b0) $display("FAIL midrst_hidden_%0d got %b exp 0", i, sprite_on1); else n_pass++;
    end
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    probe(10'd101, 10'd50, 1'b1, pon, pidx);
    n_checks++; if (pon !== 1'b1 || pidx !== 2'd1) $display("FAIL midrst_relatch got on=%b idx=%0d exp on=1 idx=1", pon, pidx); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_address();
    test_heading();
    test_pipeline();
    test_shadow_and_clip();
    test_counter();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Sits between the VGA timing generator and the 2-bit sprite ROM/palette pair.
- Takes the raster position (DrawX, DrawY, blank, vs) and a per-frame sprite position and heading from game logic.
- Computes the sprite-local ROM address, with 90° rotation for four headings from one "up" ROM image.
- Returns a pipeline-aligned opaque-pixel flag and palette index to the colour mapper; also counts opaque pixels drawn per frame.

Parameters:
- SPR_W, 14, sprite width/height in pixels (square sprite).
- ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_W.
- ROM_LAT, 1, ROM read latency in vga_clk cycles (1 or 2).

Ports:
- vga_clk, in, 1, pixel clock; all state on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- DrawX, in, 10, current raster column.
- DrawY, in, 10, current raster row.
- blank, in, 1, 1 = active video.
- vs, in, 1, vertical sync, active-low.
- pos_x, in, 10, requested sprite top-left column.
- pos_y, in, 10, requested sprite top-left row.
- dir, in, 2, heading: 0 up, 1 right, 2 down, 3 left.
- show, in, 1, sprite enable.
- rom_addr, out, ADDR_W, registered address to sprite ROM.
- rom_idx, in, 2, ROM data, valid ROM_LAT cycles after rom_addr.
- sprite_on, out, 1, aligned pixel is inside the sprite and opaque (rom_idx != 0).
- sprite_idx, out, 2, aligned palette index; 0 when sprite_on = 0.
- opaque_count, out, 8, opaque pixels drawn in the last completed frame; saturates at 255.
- frame_done, out, 1, one-cycle pulse when opaque_count updates.

Behaviour:
- Reset (async, reset_n = 0): all outputs and all internal registers go to 0 immediately. This covers latched position, heading, show, pipeline valids, the running counter and the vs history. After release, the first frame latch occurs at the next vs falling edge.
- Frame latch:
  - vs is registered once; a falling edge means vs_d = 1 and vs = 0.
  - On that cycle, pos_x, pos_y, dir and show are captured into shadow registers.
  - Changes to these inputs mid-frame have no effect until the next vs falling edge.
- Stage 0 (edge after input sample, cycle t+1):
  - dx = {1'b0,DrawX} - {1'b0,pos_x_s}, computed 11 bits wide; dy likewise.
  - hit = blank & show_s & (DrawX >= pos_x_s) & (dx < SPR_W) & (DrawY >= pos_y_s) & (dy < SPR_W).
  - Local coordinates lx = dx, ly = dy. The source pixel (sx, sy) by heading, with M = SPR_W-1:
    - up: (lx, ly)
    - right: (ly, M-lx)
    - down: (M-lx, M-ly)
    - left: (M-ly, lx)
  - rom_addr <= hit ? sx + sy*SPR_W : 0.
  - hit is registered alongside rom_addr.
  - The sprite is clipped naturally past column 639 / row 479, because blank = 0 there. No wrap-around to the left edge.
- hit is delayed ROM_LAT further cycles to align with rom_idx.
- Output stage:
  - sprite_on <= hit_aligned & (rom_idx != 0).
  - sprite_idx <= sprite_on_next ? rom_idx : 0.
  - Total latency from DrawX/DrawY sample to outputs = ROM_LAT + 2 cycles (3 at default). The colour mapper delays DrawX/DrawY/blank by the same amount.
- Counter:
  - The running 8-bit count increments on each cycle where the sprite_on register is being set to 1, saturating at 255.
  - On a vs falling edge: opaque_count <= running count (a pixel counted in the same cycle is included), running count <= 0, frame_done <= 1 for exactly one cycle.
  - A vs falling edge and a latch event in the same cycle are the same event; no priority conflict.
- Simultaneous events:
  - show_s = 0 forces hit = 0, so rom_addr = 0 and sprite_on = 0.
  - Pixels already in the pipeline still drain with the values they entered with.

Test Plan:
- Reset mid-frame while sprite_on = 1: assert reset_n = 0 → sprite_on, sprite_idx, rom_addr, opaque_count, frame_done are 0 the same cycle, before any clock edge. No sprite appears until after the next vs falling edge.
- pos=(100,50), dir=0, show=1, after latch; raster at (100,50) → rom_addr = 0 one cycle later. Raster at (113,63) → rom_addr = 195. Raster at (114,50) → hit = 0, rom_addr = 0.
- Heading check, raster (100,50) with pos (100,50): dir=1 → rom_addr = 13*14 = 182; dir=2 → 195; dir=3 → 13.
- ROM model returning a known index pattern, ROM_LAT = 1: sprite_on/sprite_idx match model for every pixel exactly 3 cycles after the DrawX/DrawY sample; index-0 pixels give sprite_on = 0. Repeat with ROM_LAT = 2 → 4 cycles.
- Change pos_x 100→300 mid-frame → output unchanged until the vs falling edge, then the sprite is drawn at 300. pos_x = 630 → only columns 630..639 drawn, nothing at column 0.
- Full frame of an all-opaque 14×14 ROM → opaque_count = 196 → saturates to 255, with a single frame_done pulse at the vs falling edge. show = 0 frame → opaque_count = 0.
